sram_boot_loader: RTL and testbench

- Upstream boot stage of the CPU core. Holds the core in reset and owns the external SRAM bus while it loads a program image.
- Image arrives as a byte stream with a valid/ready handshake, normally from a UART receiver.
- Once the image is written, it releases the bus and lets the core run from SRAM.
- Sits between the byte source and the SRAM pins. The top level muxes the SRAM pins to this block whenever bus_own=1.

---
 rtl/sram_boot_loader.sv | 197 +++++++++++++++++++
 tb/tb_sram_boot_loader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_boot_loader.sv
// sram_boot_loader: holds the core in reset, owns the SRAM bus and writes a
// byte-streamed image (addr_hi, addr_lo, len_hi, len_lo, data...) into SRAM,
// then releases the bus and the core.
// Optional build macro SRAM_BOOT_LOADER_CHECKSUM_EN adds a trailing 8-bit
// modulo-sum byte that must match the data bytes, else the loader stops in ERROR.
module sram_boot_loader #(
  parameter int ADDR_W    = 16,
  parameter int WE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              rearm,
  output logic              cpu_hold,
  output logic              bus_own,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_wdata,
  output logic              sram_wdata_oe,
  output logic              sram_not_ce,
  output logic              sram_not_oe,
  output logic              sram_not_we,
  output logic              done,
  output logic              error
);

  typedef enum logic [3:0] {
    S_HDR_AH    = 4'd0,
    S_HDR_AL    = 4'd1,
    S_HDR_LH    = 4'd2,
    S_HDR_LL    = 4'd3,
    S_DATA_WAIT = 4'd4,
    S_W_SETUP   = 4'd5,
    S_W_PULSE   = 4'd6,
    S_W_HOLD    = 4'd7,
    S_DONE      = 4'd8,
    S_ERROR     = 4'd9
`ifdef SRAM_BOOT_LOADER_CHECKSUM_EN
    , S_CKSUM   = 4'd10
`endif
  } state_t;

  // Where the stream goes once the last data byte (or an empty image) is done
`ifdef SRAM_BOOT_LOADER_CHECKSUM_EN
  localparam state_t S_END = S_CKSUM;
`else
  localparam state_t S_END = S_DONE;
`endif

  localparam logic [3:0] WE_M1 = 4'(WE_CYCLES - 1);

  state_t            r_state, w_state_nxt;
  logic [7:0]        r_addr_hi, r_len_hi;
  logic [ADDR_W-1:0] r_cur_addr, r_sram_addr;
  logic [15:0]       r_remain;
  logic [3:0]        r_we_cnt;
  logic [7:0]        r_sram_wdata;
  logic              r_in_ready, r_cpu_hold, r_bus_own, r_wdata_oe;
  logic              r_not_ce, r_not_we, r_done;
  logic              w_in_ready, w_run, w_wr, w_not_we, w_done;
  logic              w_xfer;
  logic [15:0]       w_len16, w_addr16;

  assign w_xfer   = in_valid & r_in_ready;
  assign w_len16  = {r_len_hi, in_data};
  assign w_addr16 = {r_addr_hi, in_data};

`ifdef SRAM_BOOT_LOADER_CHECKSUM_EN
  logic [7:0] r_sum;
  logic       r_error, w_error;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_HDR_AH;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HDR_AH:    if (w_xfer) w_state_nxt = S_HDR_AL;
      S_HDR_AL:    if (w_xfer) w_state_nxt = S_HDR_LH;
      S_HDR_LH:    if (w_xfer) w_state_nxt = S_HDR_LL;
      S_HDR_LL:    if (w_xfer) w_state_nxt = (w_len16 != 16'd0) ? S_DATA_WAIT : S_END;
      S_DATA_WAIT: if (w_xfer) w_state_nxt = S_W_SETUP;
      S_W_SETUP:   w_state_nxt = S_W_PULSE;
      S_W_PULSE:   if (r_we_cnt == 4'd0) w_state_nxt = S_W_HOLD;
      S_W_HOLD:    w_state_nxt = (r_remain != 16'd1) ? S_DATA_WAIT : S_END;
`ifdef SRAM_BOOT_LOADER_CHECKSUM_EN
      S_CKSUM:     if (w_xfer) w_state_nxt = (in_data == r_sum) ? S_DONE : S_ERROR;
`endif
      S_DONE,
      S_ERROR:     if (rearm) w_state_nxt = S_HDR_AH;
      default:     w_state_nxt = S_HDR_AH;
    endcase
  end

  // Output decode from the next state so registered outputs line up with it
  always_comb begin
    w_in_ready = (w_state_nxt == S_HDR_AH) || (w_state_nxt == S_HDR_AL) ||
                 (w_state_nxt == S_HDR_LH) || (w_state_nxt == S_HDR_LL) ||
                 (w_state_nxt == S_DATA_WAIT);
`ifdef SRAM_BOOT_LOADER_CHECKSUM_EN
    if (w_state_nxt == S_CKSUM) w_in_ready = 1'b1;
    w_error = (w_state_nxt == S_ERROR);
`endif
    w_wr     = (w_state_nxt == S_W_SETUP) || (w_state_nxt == S_W_PULSE) ||
               (w_state_nxt == S_W_HOLD);
    w_not_we = (w_state_nxt != S_W_PULSE);
    w_run    = (w_state_nxt != S_DONE);
    w_done   = (w_state_nxt == S_DONE);
  end

  // Registered control outputs; reset forces the bus idle immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_in_ready <= 1'b0;
      r_cpu_hold <= 1'b1;
      r_bus_own  <= 1'b1;
      r_wdata_oe <= 1'b0;
      r_not_ce   <= 1'b1;
      r_not_we   <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_in_ready <= w_in_ready;
      r_cpu_hold <= w_run;
      r_bus_own  <= w_run;
      r_wdata_oe <= w_wr;
      r_not_ce   <= ~w_wr;
      r_not_we   <= w_not_we;
      r_done     <= w_done;
    end
  end

  // Header capture, address/length counters and write-pulse timer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr_hi    <= 8'd0;
      r_len_hi     <= 8'd0;
      r_cur_addr   <= '0;
      r_remain     <= 16'd0;
      r_we_cnt     <= 4'd0;
      r_sram_addr  <= '0;
      r_sram_wdata <= 8'd0;
    end else begin
      case (r_state)
        S_HDR_AH:    if (w_xfer) r_addr_hi <= in_data;
        S_HDR_AL:    if (w_xfer) r_cur_addr <= w_addr16[ADDR_W-1:0];
        S_HDR_LH:    if (w_xfer) r_len_hi <= in_data;
        S_HDR_LL:    if (w_xfer) r_remain <= w_len16;
        S_DATA_WAIT: if (w_xfer) begin
          r_sram_wdata <= in_data;
          r_sram_addr  <= r_cur_addr;
        end
        S_W_SETUP:   r_we_cnt <= WE_M1;
        S_W_PULSE:   if (r_we_cnt != 4'd0) r_we_cnt <= r_we_cnt - 4'd1;
        S_W_HOLD: begin
          r_cur_addr <= r_cur_addr + ADDR_W'(1);
          r_remain   <= r_remain - 16'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef SRAM_BOOT_LOADER_CHECKSUM_EN
  // Running data sum (cleared on every entry to HDR_AH) and error flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sum   <= 8'd0;
      r_error <= 1'b0;
    end else begin
      r_error <= w_error;
      if (w_state_nxt == S_HDR_AH && r_state != S_HDR_AH) r_sum <= 8'd0;
      else if (r_state == S_DATA_WAIT && w_xfer)           r_sum <= r_sum + in_data;
    end
  end
  assign error = r_error;
`else
  assign error = 1'b0;
`endif

  assign in_ready      = r_in_ready;
  assign cpu_hold      = r_cpu_hold;
  assign bus_own       = r_bus_own;
  assign sram_addr     = r_sram_addr;
  assign sram_wdata    = r_sram_wdata;
  assign sram_wdata_oe = r_wdata_oe;
  assign sram_not_ce   = r_not_ce;
  assign sram_not_oe   = 1'b1;
  assign sram_not_we   = r_not_we;
  assign done          = r_done;

endmodule

// File: tb/tb_sram_boot_loader.sv
// Bench for sram_boot_loader: table of images driven through the byte
// handshake, a scoreboard of expected SRAM writes checked on each not_we
// falling edge, plus a hand-written mid-write reset sequence.
module tb_sram_boot_loader;
  localparam int ADDR_W    = 16;
  localparam int WE_CYCLES = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [7:0]        in_data = 8'd0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              rearm = 1'b0;
  logic              cpu_hold, bus_own;
  logic [ADDR_W-1:0] sram_addr;
  logic [7:0]        sram_wdata;
  logic              sram_wdata_oe, sram_not_ce, sram_not_oe, sram_not_we;
  logic              done, error;

  sram_boot_loader #(.ADDR_W(ADDR_W), .WE_CYCLES(WE_CYCLES)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .rearm(rearm), .cpu_hold(cpu_hold), .bus_own(bus_own),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_wdata_oe(sram_wdata_oe),
    .sram_not_ce(sram_not_ce), .sram_not_oe(sram_not_oe), .sram_not_we(sram_not_we),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed { logic [15:0] a; logic [7:0] d; } wr_t;
  wr_t sb[$];
  int  n_writes = 0;

  typedef struct {
    logic [0:11][7:0] b;
    int n;
    bit rnd;
    bit exp_done;
    bit exp_err;
    int exp_wr;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [95:0] bytes, input int n, input bit rnd,
                              input bit ed, input bit ee, input int ew);
    vec_t v;
    v.b = bytes; v.n = n; v.rnd = rnd;
    v.exp_done = ed; v.exp_err = ee; v.exp_wr = ew;
    return v;
  endfunction

  // Write monitor: pops the scoreboard on each pulse start and times the pulse
  logic  r_prev_we = 1'b1;
  int    r_width = 0;
  wr_t   e;
  always @(negedge clk) begin
    if (!reset) begin
      r_prev_we <= 1'b1;
      r_width   <= 0;
    end else begin
      if (!sram_not_ce) chk("in_ready_in_write", {31'd0, in_ready}, 32'd0);
      if (r_prev_we && !sram_not_we) begin
        n_writes <= n_writes + 1;
        r_width  <= 1;
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_write: addr %0h data %0h, none expected", sram_addr, sram_wdata);
        end else begin
          e = sb.pop_front();
          chk("wr_addr", 32'(sram_addr), 32'(e.a));
          chk("wr_data", 32'(sram_wdata), 32'(e.d));
          chk("wr_ce_oe", {30'd0, sram_not_ce, sram_wdata_oe}, 32'd1);
        end
      end else if (!sram_not_we) begin
        r_width <= r_width + 1;
      end else if (!r_prev_we) begin
        chk("we_width", 32'(r_width), 32'(WE_CYCLES));
      end
      r_prev_we <= sram_not_we;
    end
  end

  // Offer one byte; with rnd the valid line toggles randomly until accepted
  task automatic send(input logic [7:0] b, input bit rnd);
    int  budget = 0;
    bit  v, rdy;
    forever begin
      v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid = v;
      in_data  = v ? b : 8'($urandom);
      rdy = in_ready;
      @(posedge clk); #1;
      if (v && rdy) break;
      budget++;
      if (budget > 200) begin
        n_vec++; n_err++;
        $display("FAIL send_timeout: byte %0h not accepted, required acceptance", b);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [15:0] a, len;
    int w0, t;
    a   = {v.b[0], v.b[1]};
    len = {v.b[2], v.b[3]};
    w0  = n_writes;
    for (int i = 0; i < v.n; i++) begin
      if (i >= 4 && i < 4 + int'(len)) begin
        sb.push_back('{a: a, d: v.b[i]});
        a = a + 16'd1;
      end
      send(v.b[i], v.rnd && i >= 4);
    end
    t = 0;
    while (!(done || error) && t < 100) begin @(posedge clk); #1; t++; end
    chk($sformatf("v%0d_done", idx), {31'd0, done}, {31'd0, v.exp_done});
    chk($sformatf("v%0d_error", idx), {31'd0, error}, {31'd0, v.exp_err});
    chk($sformatf("v%0d_hold_own", idx), {30'd0, cpu_hold, bus_own},
        v.exp_done ? 32'd0 : 32'd3);
    chk($sformatf("v%0d_pins_idle", idx),
        {28'd0, sram_not_ce, sram_not_oe, sram_not_we, sram_wdata_oe}, 32'hE);
    chk($sformatf("v%0d_nwrites", idx), 32'(n_writes - w0), 32'(v.exp_wr));
    chk($sformatf("v%0d_sb_empty", idx), 32'(sb.size()), 32'd0);
    // rearm back to header state
    rearm = 1'b1;
    @(posedge clk); #1;
    rearm = 1'b0;
    chk($sformatf("v%0d_rearm", idx), {27'd0, done, error, cpu_hold, bus_own, in_ready}, 32'h7);
  endtask

  initial begin
    int t;
`ifdef SRAM_BOOT_LOADER_CHECKSUM_EN
    vecs.push_back(mk({8'h00,8'h10,8'h00,8'h02,8'h01,8'h02,8'h03,40'h0}, 7, 0, 1, 0, 2));
    vecs.push_back(mk({8'h00,8'h10,8'h00,8'h02,8'h01,8'h02,8'h04,40'h0}, 7, 0, 0, 1, 2));
    vecs.push_back(mk({8'h12,8'h34,8'h00,8'h00,8'h00,56'h0}, 5, 0, 1, 0, 0));
    vecs.push_back(mk({8'hFF,8'hFF,8'h00,8'h02,8'h11,8'h22,8'h33,40'h0}, 7, 0, 1, 0, 2));
    vecs.push_back(mk({8'h00,8'h20,8'h00,8'h03,8'h5A,8'hA5,8'h3C,8'h3B,32'h0}, 8, 1, 1, 0, 3));
`else
    vecs.push_back(mk({8'h01,8'h00,8'h00,8'h03,8'hAA,8'hBB,8'hCC,40'h0}, 7, 0, 1, 0, 3));
    vecs.push_back(mk({8'hFF,8'hFF,8'h00,8'h02,8'h11,8'h22,48'h0}, 6, 0, 1, 0, 2));
    vecs.push_back(mk({8'h12,8'h34,8'h00,8'h00,64'h0}, 4, 0, 1, 0, 0));
    vecs.push_back(mk({8'h00,8'h20,8'h00,8'h03,8'h5A,8'hA5,8'h3C,40'h0}, 7, 1, 1, 0, 3));
`endif

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", {26'd0, in_ready, cpu_hold, bus_own, done, error, sram_wdata_oe}, 32'h18);
    chk("rst_pins", {29'd0, sram_not_ce, sram_not_oe, sram_not_we}, 32'h7);
    chk("rst_addr_data", {8'd0, 16'(sram_addr), sram_wdata}, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Reset in the middle of the second write pulse, then resend the image
    sb.push_back('{a: 16'h0300, d: 8'h01});
    sb.push_back('{a: 16'h0301, d: 8'h02});
    send(8'h03, 0); send(8'h00, 0); send(8'h00, 0); send(8'h03, 0);
    send(8'h01, 0); send(8'h02, 0);
    t = 0;
    while (sram_not_we && t < 50) begin @(posedge clk); #1; t++; end
    chk("mid_pulse_reached", {31'd0, sram_not_we}, 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_pins", {28'd0, sram_not_we, sram_not_ce, cpu_hold, bus_own}, 32'hF);
    chk("mid_rst_ready", {30'd0, in_ready, sram_wdata_oe}, 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
`ifdef SRAM_BOOT_LOADER_CHECKSUM_EN
    run_vec(mk({8'h03,8'h00,8'h00,8'h03,8'h01,8'h02,8'h03,8'h06,32'h0}, 8, 0, 1, 0, 3), 99);
`else
    run_vec(mk({8'h03,8'h00,8'h00,8'h03,8'h01,8'h02,8'h03,40'h0}, 7, 0, 1, 0, 3), 99);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
